// File: rtl/cpu_pkg.sv
// cpu_pkg: ALU operation codes and operand-forwarding select encoding shared by the ID/EX stage.
package cpu_pkg;
    localparam logic [3:0] ALU_ZERO = 4'h0;
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_PASS = 4'h3;
    localparam logic [3:0] ALU_SLT  = 4'h4;
    localparam logic [3:0] ALU_SLTU = 4'h5;
    localparam logic [3:0] ALU_XOR  = 4'h6;
    localparam logic [3:0] ALU_OR   = 4'h7;
    localparam logic [3:0] ALU_AND  = 4'h8;
    localparam logic [3:0] ALU_SLL  = 4'h9;
    localparam logic [3:0] ALU_SRL  = 4'hA;
    localparam logic [3:0] ALU_SRA  = 4'hB;
    localparam logic [3:0] ALU_LAST = ALU_SRA;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_MEM  = 2'd1;
    localparam logic [1:0] FWD_WB   = 2'd2;

    function automatic logic alu_legal(input logic [3:0] code);
        return code <= ALU_LAST;
    endfunction
endpackage

// File: rtl/operand_fwd_unit.sv
// operand_fwd_unit: picks the newest value of one source register, EX/MEM before MEM/WB, never for x0.
module operand_fwd_unit
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [4:0]      idx,
    input  logic [XLEN-1:0] data,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_data,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] value,
    output logic [1:0]      sel
);
    always_comb begin
        sel   = (mem_reg_write && mem_rd != 5'd0 && mem_rd == idx) ? FWD_MEM :
                (wb_reg_write && wb_rd != 5'd0 && wb_rd == idx)    ? FWD_WB  : FWD_NONE;
        value = (sel == FWD_MEM) ? mem_data : (sel == FWD_WB) ? wb_data : data;
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with stall/flush and MEM/WB operand bypass
// feeding the EX-stage ALU.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_src1_sel,
    input  logic            id_src2_sel,
    input  logic            id_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_data,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_alu_ctrl,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_illegal
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_ctrl;
        logic            src1_sel;
        logic            src2_sel;
        logic            reg_write;
        logic            illegal;
    } stage_t;

    stage_t          q;
    logic [XLEN-1:0] fwd1, fwd2, op1, op2;
    logic [1:0]      sel1, sel2;

    operand_fwd_unit #(.XLEN(XLEN)) u_fwd_rs1 (
        .idx(q.rs1), .data(q.rs1_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .value(fwd1), .sel(sel1)
    );

    operand_fwd_unit #(.XLEN(XLEN)) u_fwd_rs2 (
        .idx(q.rs2), .data(q.rs2_data),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_data(mem_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .value(fwd2), .sel(sel2)
    );

    assign op1 = (sel1 == FWD_NONE) ? q.rs1_data : fwd1;
    assign op2 = (sel2 == FWD_NONE) ? q.rs2_data : fwd2;

    // A stalled stage re-latches its forwarded operands so they survive the producer leaving WB.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (stall) begin
            q.rs1_data <= op1;
            q.rs2_data <= op2;
        end else begin
            q <= '{valid: id_valid, pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
                   imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                   alu_ctrl: alu_legal(id_alu_ctrl) ? id_alu_ctrl : ALU_ZERO,
                   src1_sel: id_src1_sel, src2_sel: id_src2_sel,
                   reg_write: id_reg_write, illegal: !alu_legal(id_alu_ctrl)};
        end
    end

    assign ex_a          = q.src1_sel ? q.pc : op1;
    assign ex_b          = q.src2_sel ? q.imm : op2;
    assign ex_store_data = op2;
    assign ex_alu_ctrl   = q.alu_ctrl;
    assign ex_pc         = q.pc;
    assign ex_rd         = q.rd;
    assign ex_valid      = q.valid;
    assign ex_reg_write  = q.reg_write;
    assign ex_illegal    = q.illegal;
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-forwarding stage that feeds the EX-stage ALU. It captures decoded operands and ALU control each cycle and resolves RAW hazards by bypassing results from the EX/MEM and MEM/WB stages. It then presents the final `a`, `b` and `alu_ctrl` to the ALU. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
- `XLEN`, default 32: datapath width.
- `clk` in 1: clock, rising edge.
- `rstn` in 1: reset, asynchronous, active-low.
- `stall` in 1: hold stage contents.
- `flush` in 1: replace stage contents with a bubble.
- `id_valid` in 1: ID holds a real instruction.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in XLEN each: decoded values.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register indices.
- `id_alu_ctrl` in 4: ALU operation code.
- `id_src1_sel` in 1: 0 = rs1, 1 = pc.
- `id_src2_sel` in 1: 0 = rs2, 1 = imm.
- `id_reg_write` in 1: instruction writes rd.
- `mem_rd` in 5, `mem_reg_write` in 1, `mem_data` in XLEN: EX/MEM bypass source.
- `wb_rd` in 5, `wb_reg_write` in 1, `wb_data` in XLEN: MEM/WB bypass source.
- `ex_a`, `ex_b` out XLEN: ALU operands.
- `ex_alu_ctrl` out 4: ALU operation code.
- `ex_store_data` out XLEN: forwarded rs2 value.
- `ex_pc` out XLEN.
- `ex_rd` out 5.
- `ex_valid`, `ex_reg_write`, `ex_illegal` out 1 each.

## Operation
- **ALU codes:**
  - 0 = zero
  - 1 = add
  - 2 = sub
  - 3 = pass b
  - 4 = slt
  - 5 = sltu
  - 6 = xor
  - 7 = or
  - 8 = and
  - 9 = sll
  - A = srl
  - B = sra
  - C–F are illegal.
- **Register update, per edge, priority order:**
  1. `flush` loads a bubble: all fields 0, so `ex_alu_ctrl` = 0, `ex_valid` = 0, `ex_reg_write` = 0, `ex_rd` = 0.
  2. Otherwise `stall` holds all fields, except stored rs1/rs2 data, which are refreshed with their forwarded values (see Timing). This keeps the held operands correct after the producer retires out of WB.
  3. Otherwise the stage captures the `id_*` inputs.
- **Illegal code at capture:** an `id_alu_ctrl` of C–F is stored as 0 with `ex_illegal` = 1; `ex_valid` is unchanged.
- **Forwarding per source:**
  - Select `mem_data` if `mem_reg_write`, `mem_rd` ≠ 0 and `mem_rd` equals the stored rs index.
  - Else select `wb_data` under the same conditions on the WB fields.
  - Else use the stored data.
  - MEM has priority over WB. x0 is never forwarded.
- **Operand selection:**
  - `ex_a` = `src1_sel` ? stored pc : fwd_rs1.
  - `ex_b` = `src2_sel` ? stored imm : fwd_rs2.
  - `ex_store_data` = fwd_rs2 always, regardless of `src2_sel`.
- **Bubble outputs:** forwarding still evaluates, but `ex_alu_ctrl` = 0 forces the ALU result to 0.

## Timing
- **Reset:** `rstn` low asynchronously clears every register. All outputs are 0 while reset is asserted and at the first edge after release.
- **Latency:** `id_*` inputs appear at `ex_*` outputs one cycle later.
- **Combinational paths:** the forwarding paths from `mem_*`/`wb_*` to `ex_a`/`ex_b`/`ex_store_data` are combinational, with zero added latency.
- **Simultaneous `stall` and `flush`:** flush wins.
- **Stall refresh:** the refresh writes the forwarded value (not the raw `id_*` value) into the stored rs data at every stalled edge.
- **Reset mid-stall:** the stage comes out of reset as a bubble; held state is lost.

## Structure
- **Shared package `cpu_pkg`:**
  - ALU code localparams `ALU_ZERO` … `ALU_SRA`, and `ALU_LAST` = 4'hB.
  - Forward-select encoding: `FWD_NONE` = 0, `FWD_MEM` = 1, `FWD_WB` = 2.
- **Sub-module `operand_fwd_unit`:** instanced twice (rs1, rs2). Inputs are index, stored data and the mem/wb triples; outputs are the forwarded value and a 2-bit select.

## Test plan
- **Reset and capture:**
  - Stimulus: `rstn` = 0 mid-cycle.
  - Check: all outputs 0 immediately.
  - Stimulus: after release, drive `id_rs1_data` = 5, `id_imm` = 7, `src2_sel` = 1, `alu_ctrl` = 1.
  - Check: next cycle `ex_a` = 5, `ex_b` = 7, `ex_alu_ctrl` = 1, `ex_valid` = 1.
- **MEM priority:**
  - Stimulus: stored rs1 = x3 with data 1; `mem_rd` = 3 / `mem_data` = 0xAA; `wb_rd` = 3 / `wb_data` = 0xBB; both write-enables = 1.
  - Check: `ex_a` = 0xAA. Dropping `mem_reg_write` gives `ex_a` = 0xBB.
- **x0 guard:**
  - Stimulus: rs2 = x0, `mem_rd` = 0, `mem_reg_write` = 1, `mem_data` = 0xFF, stored data = 0.
  - Check: `ex_b` = 0 and `ex_store_data` = 0.
- **Stall refresh:**
  - Stimulus: stall 3 cycles with `wb_rd` = rs1 and `wb_data` = 0x1234 in cycle 1 only.
  - Check: `ex_a` = 0x1234 in cycles 2–3; other fields are unchanged and the `id_*` changes during the stall are ignored.
- **Flush over stall:**
  - Stimulus: `stall` = `flush` = 1 with a valid stage.
  - Check: next cycle `ex_valid` = 0, `ex_alu_ctrl` = 0, `ex_reg_write` = 0, `ex_rd` = 0.
- **Illegal code:**
  - Stimulus: `id_alu_ctrl` = 4'hD, `id_valid` = 1.
  - Check: next cycle `ex_alu_ctrl` = 0, `ex_illegal` = 1, `ex_valid` = 1. A following legal op clears `ex_illegal`.
